// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job initiator: default operand width,
// dispatcher FSM state encoding and the operand-pair record.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } gcd_state_e;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous operand-pair FIFO. Head is read combinationally so the
// dispatcher can inspect and pop the oldest pair in the same cycle.
// Pointers carry one extra wrap bit to tell full from empty.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_a,
    input  logic [WIDTH-1:0] push_b,
    input  logic             pop,
    output logic [WIDTH-1:0] head_a,
    output logic [WIDTH-1:0] head_b,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push while full is only legal if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_a = mem_a[rd_ptr[AW-1:0]];
    assign head_b = mem_b[rd_ptr[AW-1:0]];

    // Pointer update; reset discards every buffered pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_a[wr_ptr[AW-1:0]] <= push_a;
            mem_b[wr_ptr[AW-1:0]] <= push_b;
        end
    end

endmodule

// File: rtl/gcd_job_initiator.sv
// GCD engine initiator: buffers operand pairs, dispatches one job at a time
// over the go/done handshake, and returns results in request order.
// Zero-operand pairs are answered locally (the engine never terminates on 0).
// Optional engine watchdog: define GCD_INIT_TIMEOUT_EN.
module gcd_job_initiator
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             eng_go,
    output logic [WIDTH-1:0] eng_in1,
    output logic [WIDTH-1:0] eng_in2,
    input  logic [WIDTH-1:0] eng_out,
    input  logic             eng_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    localparam logic [1:0] IDLE    = 2'(ST_IDLE);
    localparam logic [1:0] ISSUE   = 2'(ST_ISSUE);
    localparam logic [1:0] WAIT    = 2'(ST_WAIT);
    localparam logic [1:0] DELIVER = 2'(ST_DELIVER);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gcd_job_initiator: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("gcd_job_initiator: TIMEOUT must be >= 1");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             head_zero;
    logic             wd_abort;

    assign req_ready = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign head_zero = (head_a == '0) || (head_b == '0);
    assign eng_go    = (state == ISSUE);
    assign res_valid = (state == DELIVER);
    assign busy      = !fifo_empty || (state != IDLE);

    gcd_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (req_valid && req_ready),
        .push_a (req_a),
        .push_b (req_b),
        .pop    (fifo_pop),
        .head_a (head_a),
        .head_b (head_b),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef GCD_INIT_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt;

    // Abort once the engine has spent TIMEOUT cycles in WAIT without done.
    assign wd_abort = (state == WAIT) && !eng_done && (wd_cnt == WD_LAST);

    // Watchdog counter and error flag; flag is re-decided at every dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            res_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                wd_cnt <= '0;
            else if (state == WAIT)
                wd_cnt <= wd_cnt + 1'b1;

            if (fifo_pop)
                res_err <= 1'b0;
            else if (wd_abort)
                res_err <= 1'b1;
        end
    end
`else
    assign wd_abort = 1'b0;
    assign res_err  = 1'b0;
`endif

    // Dispatcher FSM: operands and result are registered so they stay stable
    // across the engine run and the downstream stall respectively.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            eng_in1  <= '0;
            eng_in2  <= '0;
            res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_zero) begin
                            // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer.
                            res_data <= head_a | head_b;
                            state    <= DELIVER;
                        end else begin
                            eng_in1 <= head_a;
                            eng_in2 <= head_b;
                            state   <= ISSUE;
                        end
                    end
                end
                // Done seen here may be stale from the previous job; skip it.
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (eng_done) begin
                        res_data <= eng_out;
                        state    <= DELIVER;
                    end else if (wd_abort) begin
                        res_data <= '0;
                        state    <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_initiator.sv
// Self-checking bench for gcd_job_initiator with a behavioural GCD engine,
// a result scoreboard and a vector table plus directed corner sequences.
module tb_gcd_job_initiator;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         eng_go;
    logic [W-1:0] eng_in1;
    logic [W-1:0] eng_in2;
    logic [W-1:0] eng_out;
    logic         eng_done;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         busy;

    gcd_job_initiator #(.WIDTH(W), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .eng_go    (eng_go),
        .eng_in1   (eng_in1),
        .eng_in2   (eng_in2),
        .eng_out   (eng_out),
        .eng_done  (eng_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: done is a level that drops on go and rises eng_lat
    // running cycles later; stall freezes it to model a hung engine.
    int           eng_lat   = 3;
    logic         eng_stall = 1'b0;
    int           go_cnt    = 0;
    int           stab_bad  = 0;
    logic         m_run     = 1'b0;
    int           m_cnt     = 0;
    logic [W-1:0] m_a, m_b;

    always @(posedge clk) begin
        if (rst) begin
            m_run    <= 1'b0;
            eng_done <= 1'b0;
            eng_out  <= '0;
        end else if (eng_go) begin
            go_cnt   <= go_cnt + 1;
            m_run    <= 1'b1;
            eng_done <= 1'b0;
            m_a      <= eng_in1;
            m_b      <= eng_in2;
            m_cnt    <= eng_lat;
        end else if (m_run) begin
            if (eng_in1 !== m_a || eng_in2 !== m_b) stab_bad <= stab_bad + 1;
            if (!eng_stall) begin
                if (m_cnt <= 1) begin
                    eng_done <= 1'b1;
                    eng_out  <= ref_gcd(m_a, m_b);
                    m_run    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Scoreboard: expected {err,data} queued on accept, compared on handshake.
    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_err", 32'(res_err), 32'(e.err));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input logic err);
        int n;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 500) begin
                check("req_ready_timeout", 32'(req_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        sb.push_back('{err: err, data: exp});
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!eng_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(eng_done), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int           g0;
        int           n;
        int           unstable;
        logic [W-1:0] hold_d;
        logic [W-1:0] fa[5];
        logic [W-1:0] fb[5];

        vecs[0] = '{a: 16'd48,    b: 16'd18,  exp: 16'd6,   lat: 10};
        vecs[1] = '{a: 16'd0,     b: 16'd35,  exp: 16'd35,  lat: 3};
        vecs[2] = '{a: 16'd0,     b: 16'd0,   exp: 16'd0,   lat: 3};
        vecs[3] = '{a: 16'd21,    b: 16'd14,  exp: 16'd7,   lat: 1};
        vecs[4] = '{a: 16'd77,    b: 16'd0,   exp: 16'd77,  lat: 3};
        vecs[5] = '{a: 16'd17,    b: 16'd5,   exp: 16'd1,   lat: 6};
        vecs[6] = '{a: 16'd65535, b: 16'd255, exp: 16'd255, lat: 4};
        vecs[7] = '{a: 16'd12,    b: 16'd12,  exp: 16'd12,  lat: 2};

        fa = '{16'd48, 16'd100, 16'd9, 16'd1000, 16'd36};
        fb = '{16'd18, 16'd75,  16'd6, 16'd250,  16'd24};

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_eng_go", 32'(eng_go), 32'd0);
        check("rst_eng_in1", 32'(eng_in1), 32'd0);
        check("rst_eng_in2", 32'(eng_in2), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Table vectors, one job at a time with latency checks.
        for (int i = 0; i < NV; i++) begin
            eng_lat = vecs[i].lat;
            g0 = go_cnt;
            send(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
            if (vecs[i].a == 0 || vecs[i].b == 0) begin
                check("zero_pre_valid", 32'(res_valid), 32'd0);
                @(posedge clk); #1;
                check("zero_valid_lat", 32'(res_valid), 32'd1);
                drain();
                check("zero_no_go", 32'(go_cnt - g0), 32'd0);
            end else begin
                check("go_pre", 32'(eng_go), 32'd0);
                @(posedge clk); #1;
                check("go_lat", 32'(eng_go), 32'd1);
                check("go_in1", 32'(eng_in1), 32'(vecs[i].a));
                check("go_in2", 32'(eng_in2), 32'(vecs[i].b));
                @(posedge clk); #1;
                check("go_single", 32'(eng_go), 32'd0);
                wait_done();
                check("valid_at_done", 32'(res_valid), 32'd0);
                @(negedge clk);
                check("valid_after_done", 32'(res_valid), 32'd1);
                drain();
                check("one_go", 32'(go_cnt - g0), 32'd1);
            end
        end

        // Engine stalled: 1 in flight + 4 buffered fills the FIFO.
        eng_stall = 1'b1;
        eng_lat = 4;
        for (int i = 0; i < 5; i++) send(fa[i], fb[i], ref_gcd(fa[i], fb[i]), 1'b0);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("full_ready_hold", 32'(req_ready), 32'd0);
        eng_stall = 1'b0;
        drain();
        check("after_full_ready", 32'(req_ready), 32'd1);

        // Downstream stall in DELIVER for 20 cycles.
        res_ready = 1'b0;
        eng_lat = 3;
        send(16'd100, 16'd75, 16'd25, 1'b0);
        send(16'd81, 16'd27, 16'd27, 1'b0);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 32'(res_valid), 32'd1);
        hold_d = res_data;
        g0 = go_cnt;
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            if (!res_valid || res_data !== hold_d) unstable++;
        end
        check("hold_stable", 32'(unstable), 32'd0);
        check("hold_data", 32'(hold_d), 32'd25);
        check("hold_no_go", 32'(go_cnt - g0), 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_drop", 32'(res_valid), 32'd0);
        check("hs_go_early", 32'(eng_go), 32'd0);
        @(posedge clk); #1;
        check("hs_next_go", 32'(eng_go), 32'd1);
        drain();

        // Reset during WAIT with 3 pairs buffered.
        eng_stall = 1'b1;
        send(16'd48, 16'd18, 16'd6, 1'b0);
        send(16'd9, 16'd6, 16'd3, 1'b0);
        send(16'd10, 16'd4, 16'd2, 1'b0);
        send(16'd15, 16'd5, 16'd5, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_go", 32'(eng_go), 32'd0);
        check("mid_rst_in1", 32'(eng_in1), 32'd0);
        check("mid_rst_in2", 32'(eng_in2), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_data", 32'(res_data), 32'd0);
        check("mid_rst_err", 32'(res_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        eng_stall = 1'b0;
        send(16'd21, 16'd14, 16'd7, 1'b0);
        drain();

`ifdef GCD_INIT_TIMEOUT_EN
        // Hung engine: abort after 16 WAIT cycles, then a normal job.
        eng_stall = 1'b1;
        send(16'd48, 16'd18, 16'd0, 1'b1);
        @(posedge clk); #1;
        check("to_go", 32'(eng_go), 32'd1);
        repeat (16) @(posedge clk);
        #1;
        check("to_not_yet", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("to_valid", 32'(res_valid), 32'd1);
        check("to_data", 32'(res_data), 32'd0);
        check("to_err", 32'(res_err), 32'd1);
        drain();
        eng_stall = 1'b0;
        eng_lat = 5;
        repeat (10) @(posedge clk);
        #1;
        send(16'd21, 16'd14, 16'd7, 1'b0);
        drain();
`endif

        check("operand_stability", 32'(stab_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_job_initiator.md
Name: gcd_job_initiator

Overview:
Initiator side of the GCD engine go/done handshake. Buffers operand pairs from an upstream valid/ready stream and dispatches them one at a time to the GCD engine. It holds each pair's operands stable while the engine runs, captures the engine result on done, and returns it on a downstream valid/ready stream in request order. Sits between the system bus adapter and the GCD engine.

Parameters:
WIDTH, 16, operand/result width; matches GCD engine in1/in2/out.
DEPTH, 4, operand-pair FIFO entries; power of two, >= 2.
TIMEOUT, 1024, engine watchdog limit in cycles (used only with GCD_INIT_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  upstream pair valid.
req_ready  out  1  FIFO not full.
req_a  in  WIDTH  operand A.
req_b  in  WIDTH  operand B.
eng_go  out  1  one-cycle start pulse to engine.
eng_in1  out  WIDTH  operand A to engine.
eng_in2  out  WIDTH  operand B to engine.
eng_out  in  WIDTH  engine result.
eng_done  in  1  engine completion level.
res_valid  out  1  result valid.
res_ready  in  1  downstream accepts result.
res_data  out  WIDTH  GCD result.
res_err  out  1  result produced by watchdog abort.
busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (synchronous, rst high at clk edge): FSM to IDLE; FIFO emptied; eng_go=0; eng_in1=eng_in2=0; res_valid=0; res_data=0; res_err=0; busy=0; req_ready=1 from the cycle after reset. Reset mid-operation abandons the in-flight job and the buffered pairs. The engine shares rst, so no engine cleanup is required.
- Request accept: on req_valid&&req_ready at the edge, push {req_a,req_b}. req_ready = !full. Simultaneous push and pop in the same cycle are allowed when full; req_ready still reflects full (no pass-through).
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE, FIFO empty: stay.
- IDLE, FIFO non-empty, head has a==0 or b==0: pop the head. Go to DELIVER with res_data = a|b (gcd(x,0)=x; gcd(0,0)=0). No eng_go is issued, because the engine does not terminate on zero operands.
- IDLE, FIFO non-empty, both operands nonzero: pop the head. Load eng_in1/eng_in2. Go to ISSUE.
- ISSUE: eng_go=1 for exactly this cycle. Go to WAIT.
- WAIT: eng_in1/eng_in2 held stable. On the first cycle with eng_done=1, register eng_out into res_data and go to DELIVER. eng_done asserted during ISSUE is ignored.
- DELIVER: res_valid=1. res_data/res_err are stable while res_ready=0. On res_valid&&res_ready, go to IDLE. The next dispatch starts at the earliest on the cycle after the handshake.
- Latency, no backpressure: the pair is accepted at edge N, popped at N+1, eng_go is high in cycle N+2, res_valid follows 1 cycle after eng_done. A zero-operand pair gives res_valid 2 cycles after acceptance.
- Ordering: results are strictly in request order; only one job is in flight.
- Widths: all data WIDTH bits unsigned; no arithmetic beyond the OR on the zero path.
- FIFO pointers wrap modulo DEPTH; full/empty use an extra pointer bit.

Optional Feature:
GCD_INIT_TIMEOUT_EN:
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT with eng_done still 0, go to DELIVER with res_data=0 and res_err=1. A late eng_done after the abort is ignored until the next ISSUE.
- Undefined: no counter; WAIT is unbounded; res_err tied 0.

Decomposition:
- Package gcd_pkg: WIDTH default constant; FSM state enum (IDLE/ISSUE/WAIT/DELIVER); pair struct {a,b}.
- One sub-module: gcd_pair_fifo, a synchronous FIFO with parameters WIDTH and DEPTH, push/pop, full/empty, head data registered-read-free (combinational head).

Test Plan:
- Pair (48,18), engine model returns 6 after 10 cycles: exactly one eng_go pulse with eng_in1=48, eng_in2=18 held stable through WAIT; res_data=6, res_valid 1 cycle after eng_done.
- Pairs (0,35) then (0,0): no eng_go pulses; results 35 then 0 in order, each with res_err=0.
- Engine model stalled, push 5 pairs with DEPTH=4: after 1 in flight plus 4 buffered, req_ready=0. Release the engine: 5 results arrive in order.
- res_ready held 0 for 20 cycles in DELIVER: res_data/res_valid stable, no new eng_go. Then res_ready=1: next job issues the cycle after the handshake.
- rst asserted during WAIT with 3 pairs buffered: the next cycle shows all outputs at reset values and busy=0. A subsequent pair (21,14) returns 7.
- With GCD_INIT_TIMEOUT_EN and TIMEOUT=16, engine never asserts done: after 16 WAIT cycles, res_valid=1, res_data=0, res_err=1. The next job completes normally with res_err=0.
